seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 49 ++++
 rtl/seq_alu_core.sv | 38 +++
 rtl/seq_alu.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode and FSM state types shared by the sequential ALU.
//   alu_op_e   - 5-bit operation codes (18-31 are reserved and return 0)
//   state_e    - IDLE / CALC / DONE controller states
//   is_iter_op - true for the multi-cycle multiply/divide opcodes
//   is_div_op  - true for DIV/DIVU/REM/REMU
package seq_alu_pkg;

  localparam int unsigned OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRA    = 5'd6,
    OP_SRL    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  localparam logic [OP_W-1:0] OP_ITER_FIRST = 5'd10;
  localparam logic [OP_W-1:0] OP_ITER_LAST  = 5'd17;
  localparam logic [OP_W-1:0] OP_DIV_FIRST  = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_iter_op(input logic [OP_W-1:0] op);
    return (op >= OP_ITER_FIRST) && (op <= OP_ITER_LAST);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op >= OP_DIV_FIRST) && (op <= OP_ITER_LAST);
  endfunction

endpackage

// File: rtl/seq_alu_core.sv
// alu_core: combinational single-cycle ALU (opcodes 0-9); any other code yields 0.
//   i_op  - operation code
//   i_a   - first operand, i_b - second operand (shifts use i_b[SHW-1:0] only)
//   o_res - result
module alu_core
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_res
);

  logic [SHW-1:0] shamt;
  assign shamt = i_b[SHW-1:0];

  // Single-cycle result select.
  always_comb begin
    o_res = '0;
    case (i_op)
      OP_ADD:  o_res = i_a + i_b;
      OP_SUB:  o_res = i_a - i_b;
      OP_SLL:  o_res = i_a << shamt;
      OP_SLT:  o_res = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: o_res = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      OP_XOR:  o_res = i_a ^ i_b;
      OP_SRA:  o_res = $unsigned($signed(i_a) >>> shamt);
      OP_SRL:  o_res = i_a >> shamt;
      OP_OR:   o_res = i_a | i_b;
      OP_AND:  o_res = i_a & i_b;
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshakes on request and result.
//   i_clk, i_rst           - clock, synchronous active-high reset
//   i_valid / o_ready      - request handshake (accepted only in IDLE)
//   i_alu_op, i_op_a/b     - opcode and operands, captured on acceptance
//   o_valid / i_ready      - result handshake; o_alu_data held until taken
//   o_busy                 - high while iterating (CALC)
// Ops 0-9, reserved codes and divide corner cases finish in one cycle; other
// multiply/divide ops iterate one bit per cycle for XLEN cycles through a
// single shared adder/subtractor.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [OP_W-1:0] i_alu_op,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_alu_data,
  output logic            o_busy
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;        // multiplicand, or divisor magnitude
  logic [XLEN-1:0] acc_q, acc_d;    // product high half, or partial remainder
  logic [XLEN-1:0] lo_q, lo_d;      // multiplier/product low half, or dividend/quotient
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept, signed_div_in, a_neg_in, b_neg_in;
  logic            div_zero_in, div_ovf_in, shortcut_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in, core_res, shortcut_res;

  assign accept        = (state_q == ST_IDLE) && i_valid;
  assign signed_div_in = (i_alu_op == OP_DIV) || (i_alu_op == OP_REM);
  assign a_neg_in      = signed_div_in && i_op_a[XLEN-1];
  assign b_neg_in      = signed_div_in && i_op_b[XLEN-1];
  assign a_mag_in      = a_neg_in ? -i_op_a : i_op_a;
  assign b_mag_in      = b_neg_in ? -i_op_b : i_op_b;
  assign div_zero_in   = is_div_op(i_alu_op) && (i_op_b == '0);
  assign div_ovf_in    = signed_div_in && (i_op_a == MOST_NEG) && (i_op_b == '1);
  assign shortcut_in   = div_zero_in || div_ovf_in;

  alu_core #(.XLEN(XLEN), .SHW(SHW)) u_core (
    .i_op  (i_alu_op),
    .i_a   (i_op_a),
    .i_b   (i_op_b),
    .o_res (core_res)
  );

  // Divide-by-zero and signed-overflow results, which skip iteration.
  always_comb begin
    shortcut_res = '0;
    if (div_zero_in) begin
      if ((i_alu_op == OP_DIV) || (i_alu_op == OP_DIVU)) shortcut_res = '1;
      else shortcut_res = i_op_a;
    end else if (div_ovf_in) begin
      if (i_alu_op == OP_DIV) shortcut_res = i_op_a;
      else shortcut_res = '0;
    end else begin
      shortcut_res = '0;
    end
  end

  // ---------------- shared adder/subtractor step ----------------
  // The adder is XLEN bits wide; the (XLEN+1)-th result bit is rebuilt from
  // the operands' extension bits and the carry-out.
  logic            is_mul, mul_a_signed, mul_b_signed, mul_bit, mul_sub, a_ext;
  logic [XLEN-1:0] add_x, add_y, add_sum;
  logic            add_x_ext, add_y_ext, add_cin, add_cout, add_top, div_ge;
  logic [XLEN-1:0] acc_nx, lo_nx, final_res;

  assign is_mul       = (op_q >= OP_ITER_FIRST) && (op_q < OP_DIV_FIRST);
  assign mul_a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU);
  assign mul_b_signed = (op_q == OP_MULH);
  assign mul_bit      = lo_q[0];
  // Signed multiplier: the top bit carries weight -2^(XLEN-1), so subtract.
  assign mul_sub      = mul_b_signed && mul_bit && (cnt_q == CNT_LAST);
  assign a_ext        = mul_a_signed && a_q[XLEN-1];

  // Adder operand select for a multiply or divide step.
  always_comb begin
    add_x     = '0;
    add_y     = '0;
    add_x_ext = 1'b0;
    add_y_ext = 1'b0;
    add_cin   = 1'b0;
    if (is_mul) begin
      add_x     = acc_q;
      add_x_ext = mul_a_signed && acc_q[XLEN-1];
      if (mul_bit) begin
        add_y     = mul_sub ? ~a_q : a_q;
        add_y_ext = mul_sub ? ~a_ext : a_ext;
        add_cin   = mul_sub;
      end else begin
        add_y     = '0;
        add_y_ext = 1'b0;
        add_cin   = 1'b0;
      end
    end else begin
      // Trial subtract of the divisor from the left-shifted remainder.
      add_x     = {acc_q[XLEN-2:0], lo_q[XLEN-1]};
      add_x_ext = acc_q[XLEN-1];
      add_y     = ~a_q;
      add_y_ext = 1'b1;
      add_cin   = 1'b1;
    end
  end

  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {{XLEN{1'b0}}, add_cin};
  assign add_top             = add_x_ext ^ add_y_ext ^ add_cout;
  assign div_ge              = ~add_top;

  // Next iterator state for one multiply or divide step.
  always_comb begin
    acc_nx = acc_q;
    lo_nx  = lo_q;
    if (is_mul) begin
      acc_nx = {add_top, add_sum[XLEN-1:1]};
      lo_nx  = {add_sum[0], lo_q[XLEN-1:1]};
    end else begin
      acc_nx = div_ge ? add_sum : add_x;
      lo_nx  = {lo_q[XLEN-2:0], div_ge};
    end
  end

  // Final result on the last step, with sign fix-up for signed divide.
  always_comb begin
    final_res = '0;
    case (op_q)
      OP_MUL:                        final_res = lo_nx;
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = acc_nx;
      OP_DIV, OP_DIVU:               final_res = qneg_q ? -lo_nx : lo_nx;
      OP_REM, OP_REMU:               final_res = rneg_q ? -acc_nx : acc_nx;
      default:                       final_res = '0;
    endcase
  end

  // ---------------- FSM ----------------
  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) state_d = (is_iter_op(i_alu_op) && !shortcut_in) ? ST_CALC : ST_DONE;
        else state_d = ST_IDLE;
      end
      ST_CALC: begin
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
        else state_d = ST_CALC;
      end
      ST_DONE: begin
        if (i_ready) state_d = ST_IDLE;
        else state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      ST_IDLE: o_ready = 1'b1;
      ST_CALC: o_busy  = 1'b1;
      ST_DONE: o_valid = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

  // Datapath next values: capture on acceptance, iterate in CALC, else hold.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    if (accept) begin
      op_d  = i_alu_op;
      acc_d = '0;
      cnt_d = '0;
      if (is_div_op(i_alu_op)) begin
        a_d    = b_mag_in;
        lo_d   = a_mag_in;
        qneg_d = a_neg_in ^ b_neg_in;
        rneg_d = a_neg_in;
      end else begin
        a_d    = i_op_a;
        lo_d   = i_op_b;
        qneg_d = 1'b0;
        rneg_d = 1'b0;
      end
      if (shortcut_in) result_d = shortcut_res;
      else if (is_iter_op(i_alu_op)) result_d = result_q;
      else result_d = core_res;
    end else if (state_q == ST_CALC) begin
      acc_d = acc_nx;
      lo_d  = lo_nx;
      cnt_d = cnt_q + SHW'(1);
      if (cnt_q == CNT_LAST) result_d = final_res;
      else result_d = result_q;
    end else begin
      result_d = result_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q     <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign o_alu_data = result_q;

endmodule
